// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: keypad-to-ALU controller for the calculator.
// Decodes key events into operand entry, operator selection, equals and
// clear. Holds the X (entry/result) and Y (stored operand) registers, and
// issues one operation at a time to the shared multi-cycle ALU using a
// start/done handshake with an abort timeout.

module calc_key_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int MAXDIG  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        newkey,
    input  logic [4:0]  keycode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        alu_ovw,
    output logic [15:0] disp_value,
    output logic        neg_led,
    output logic        ovw_led,
    output logic        busy
);

    localparam int CNTW = $clog2(MAXDIG + 1);
    localparam int TMOW = $clog2(TIMEOUT + 1);

    localparam logic [4:0] KEY_CLR  = 5'h00;
    localparam logic [4:0] KEY_ADD  = 5'h01;
    localparam logic [4:0] KEY_SUB  = 5'h02;
    localparam logic [4:0] KEY_MUL  = 5'h03;
    localparam logic [4:0] KEY_EQU  = 5'h04;
    localparam logic [4:0] KEY_CE   = 5'h05;
    localparam logic [4:0] KEY_BKSP = 5'h06;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_OPWAIT = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       x_q, x_d;
    logic [15:0]       y_q, y_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        nextOp_q, nextOp_d;
    logic              chain_q, chain_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              fresh_q, fresh_d;
    logic              entered_q, entered_d;
    logic [TMOW-1:0]   tmo_q, tmo_d;
    logic [15:0]       aluA_q, aluA_d;
    logic [15:0]       aluB_q, aluB_d;
    logic [1:0]        aluOp_q, aluOp_d;
    logic              aluStart_q, aluStart_d;
    logic              ovw_q, ovw_d;

    logic              keyDigit;
    logic              keyClr;
    logic              keyOper;
    logic              keyEqu;
    logic              keyCe;
    logic              keyBksp;
    logic [1:0]        keyOp;
    logic [3:0]        digit;
    logic              issueReq;

    // Key decode: a key is only meaningful in the cycle newkey is high.
    assign keyDigit = newkey && keycode[4];
    assign keyClr   = newkey && (keycode == KEY_CLR);
    assign keyOper  = newkey && ((keycode == KEY_ADD) || (keycode == KEY_SUB) ||
                                 (keycode == KEY_MUL));
    assign keyEqu   = newkey && (keycode == KEY_EQU);
    assign keyCe    = newkey && (keycode == KEY_CE);
    assign keyBksp  = newkey && (keycode == KEY_BKSP);
    assign keyOp    = keycode[1:0] - 2'd1;
    assign digit    = keycode[3:0];

    // Next-state logic for the sequencer and all datapath registers.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        op_d       = op_q;
        nextOp_d   = nextOp_q;
        chain_d    = chain_q;
        cnt_d      = cnt_q;
        fresh_d    = fresh_q;
        entered_d  = entered_q;
        tmo_d      = tmo_q;
        aluA_d     = aluA_q;
        aluB_d     = aluB_q;
        aluOp_d    = aluOp_q;
        aluStart_d = 1'b0;
        ovw_d      = ovw_q;
        issueReq   = 1'b0;

        case (state_q)
            ST_ENTRY, ST_OPWAIT: begin
                if (keyDigit) begin
                    if (fresh_q) begin
                        x_d     = {12'h000, digit};
                        cnt_d   = CNTW'(1);
                        fresh_d = 1'b0;
                    end else if (cnt_q < CNTW'(MAXDIG)) begin
                        x_d   = {x_q[11:0], digit};
                        cnt_d = cnt_q + CNTW'(1);
                    end
                    if (state_q == ST_OPWAIT) begin
                        entered_d = 1'b1;
                    end
                end else if (keyBksp) begin
                    x_d   = x_q >> 4;
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNTW'(1);
                end else if (keyCe) begin
                    x_d   = 16'h0000;
                    cnt_d = '0;
                end else if (keyOper) begin
                    if (state_q == ST_ENTRY) begin
                        y_d       = x_q;
                        op_d      = keyOp;
                        fresh_d   = 1'b1;
                        entered_d = 1'b0;
                        state_d   = ST_OPWAIT;
                    end else if (!entered_q) begin
                        op_d = keyOp;
                    end else begin
                        chain_d  = 1'b1;
                        nextOp_d = keyOp;
                        issueReq = 1'b1;
                    end
                end else if (keyEqu && (state_q == ST_OPWAIT)) begin
                    chain_d  = 1'b0;
                    issueReq = 1'b1;
                end
            end

            ST_ISSUE: begin
                tmo_d   = tmo_q + TMOW'(1);
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (alu_done) begin
                    x_d       = alu_result;
                    ovw_d     = alu_ovw;
                    fresh_d   = 1'b1;
                    entered_d = 1'b0;
                    cnt_d     = '0;
                    if (chain_q) begin
                        y_d     = alu_result;
                        op_d    = nextOp_q;
                        state_d = ST_OPWAIT;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end else if (tmo_q >= TMOW'(TIMEOUT - 1)) begin
                    ovw_d     = 1'b1;
                    fresh_d   = 1'b1;
                    entered_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_ENTRY;
                end else begin
                    tmo_d = tmo_q + TMOW'(1);
                end
            end

            default: begin
                state_d = ST_ENTRY;
            end
        endcase

        // Operands are frozen here and stay put until the operation ends.
        if (issueReq) begin
            aluA_d     = y_q;
            aluB_d     = x_q;
            aluOp_d    = op_q;
            aluStart_d = 1'b1;
            tmo_d      = '0;
            state_d    = ST_ISSUE;
        end

        // Clear wins over everything, including a coincident alu_done.
        if (keyClr) begin
            state_d    = ST_ENTRY;
            x_d        = 16'h0000;
            y_d        = 16'h0000;
            op_d       = 2'b00;
            nextOp_d   = 2'b00;
            chain_d    = 1'b0;
            cnt_d      = '0;
            fresh_d    = 1'b1;
            entered_d  = 1'b0;
            tmo_d      = '0;
            aluA_d     = 16'h0000;
            aluB_d     = 16'h0000;
            aluOp_d    = 2'b00;
            aluStart_d = 1'b0;
            ovw_d      = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_ENTRY;
            x_q        <= 16'h0000;
            y_q        <= 16'h0000;
            op_q       <= 2'b00;
            nextOp_q   <= 2'b00;
            chain_q    <= 1'b0;
            cnt_q      <= '0;
            fresh_q    <= 1'b1;
            entered_q  <= 1'b0;
            tmo_q      <= '0;
            aluA_q     <= 16'h0000;
            aluB_q     <= 16'h0000;
            aluOp_q    <= 2'b00;
            aluStart_q <= 1'b0;
            ovw_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            op_q       <= op_d;
            nextOp_q   <= nextOp_d;
            chain_q    <= chain_d;
            cnt_q      <= cnt_d;
            fresh_q    <= fresh_d;
            entered_q  <= entered_d;
            tmo_q      <= tmo_d;
            aluA_q     <= aluA_d;
            aluB_q     <= aluB_d;
            aluOp_q    <= aluOp_d;
            aluStart_q <= aluStart_d;
            ovw_q      <= ovw_d;
        end
    end

    assign alu_a      = aluA_q;
    assign alu_b      = aluB_q;
    assign alu_op     = aluOp_q;
    assign alu_start  = aluStart_q;
    assign disp_value = x_q;
    assign neg_led    = x_q[15];
    assign ovw_led    = ovw_q;
    assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer: scoreboard bench for the calculator key sequencer.
// Stimulus pushes expected issues, completions and per-key display states
// into queues; independent monitors pop and compare when the DUT presents
// an alu_start pulse, a busy falling edge, or a sampled key.
`timescale 1ns/1ps

module tb_calc_key_sequencer;

    typedef struct {
        logic [15:0] disp;
        logic        neg;
        logic        ovw;
        logic        busy;
    } keyExp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } issueExp_t;

    typedef struct {
        logic [15:0] disp;
        logic        neg;
        logic        ovw;
        int          busyCycles;
    } doneExp_t;

    typedef struct {
        int          delay;
        logic [15:0] res;
        logic        ovw;
    } resp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        newkey = 1'b0;
    logic [4:0]  keycode = 5'h00;
    logic        keyCheck = 1'b0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        alu_ovw;
    logic [15:0] disp_value;
    logic        neg_led;
    logic        ovw_led;
    logic        busy;

    logic        respDone = 1'b0;
    logic [15:0] respRes = 16'h0000;
    logic        respOvw = 1'b0;
    logic        manualDone = 1'b0;
    logic [15:0] manualRes = 16'h0000;
    logic        manualOvw = 1'b0;

    int checks = 0;
    int errors = 0;

    keyExp_t   keyQ[$];
    issueExp_t issueQ[$];
    doneExp_t  doneQ[$];
    resp_t     respQ[$];

    keyExp_t   keMon;
    issueExp_t ieMon;
    doneExp_t  deMon;
    resp_t     rrMon;
    logic      prevBusy = 1'b0;
    int        busyCount = 0;

    assign alu_done   = respDone | manualDone;
    assign alu_result = manualDone ? manualRes : respRes;
    assign alu_ovw    = manualDone ? manualOvw : respOvw;

    calc_key_sequencer #(.TIMEOUT(64), .MAXDIG(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .newkey     (newkey),
        .keycode    (keycode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_ovw    (alu_ovw),
        .disp_value (disp_value),
        .neg_led    (neg_led),
        .ovw_led    (ovw_led),
        .busy       (busy)
    );

    // 5 MHz system clock.
    always #100 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic pushIssue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        issueExp_t e;
        e.a = a; e.b = b; e.op = op;
        issueQ.push_back(e);
    endtask

    task automatic pushResp(input int delay, input logic [15:0] res, input logic ovw);
        resp_t r;
        r.delay = delay; r.res = res; r.ovw = ovw;
        respQ.push_back(r);
    endtask

    task automatic pushDone(input logic [15:0] disp, input logic neg, input logic ovw,
                            input int busyCycles);
        doneExp_t e;
        e.disp = disp; e.neg = neg; e.ovw = ovw; e.busyCycles = busyCycles;
        doneQ.push_back(e);
    endtask

    // One key press; the expected display state after the key is queued.
    task automatic applyStimulus(input logic [4:0] code, input logic [15:0] expDisp,
                                 input logic expOvw, input logic expBusy);
        keyExp_t e;
        @(negedge clk);
        e.disp = expDisp; e.neg = expDisp[15]; e.ovw = expOvw; e.busy = expBusy;
        keyQ.push_back(e);
        keycode  = code;
        newkey   = 1'b1;
        keyCheck = 1'b1;
        @(negedge clk);
        newkey   = 1'b0;
        keyCheck = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while (busy && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("[TB] FAIL wait_idle: got busy=1 after %0d cycles expected busy=0", n);
        end
        @(negedge clk);
    endtask

    task automatic lateDone(input logic [15:0] res, input logic ovw);
        @(negedge clk);
        manualRes  = res;
        manualOvw  = ovw;
        manualDone = 1'b1;
        @(negedge clk);
        manualDone = 1'b0;
    endtask

    // ALU model: answers each issue with the next queued response, if any.
    initial forever begin
        @(negedge clk);
        if (alu_start === 1'b1 && respQ.size() > 0) begin
            rrMon = respQ.pop_front();
            repeat (rrMon.delay) @(negedge clk);
            respRes  = rrMon.res;
            respOvw  = rrMon.ovw;
            respDone = 1'b1;
            @(negedge clk);
            respDone = 1'b0;
        end
    end

    // Issue monitor: every alu_start cycle must match a queued issue.
    initial forever begin
        @(negedge clk);
        if (alu_start === 1'b1) begin
            if (issueQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_issue: got alu_start=1 a=%h b=%h expected no issue",
                         alu_a, alu_b);
            end else begin
                ieMon = issueQ.pop_front();
                checkOutput("issue_a", 32'(alu_a), 32'(ieMon.a));
                checkOutput("issue_b", 32'(alu_b), 32'(ieMon.b));
                checkOutput("issue_op", 32'(alu_op), 32'(ieMon.op));
            end
        end
    end

    // Completion monitor: fires when busy falls.
    initial forever begin
        @(negedge clk);
        if (busy) busyCount++;
        if (prevBusy && !busy) begin
            if (doneQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got busy fall disp=%h expected none", disp_value);
            end else begin
                deMon = doneQ.pop_front();
                checkOutput("done_disp", 32'(disp_value), 32'(deMon.disp));
                checkOutput("done_neg", 32'(neg_led), 32'(deMon.neg));
                checkOutput("done_ovw", 32'(ovw_led), 32'(deMon.ovw));
                if (deMon.busyCycles >= 0) begin
                    checkOutput("busy_cycles", 32'(busyCount), 32'(deMon.busyCycles));
                end
            end
            busyCount = 0;
        end
        prevBusy = busy;
    end

    // Key monitor: compares display state one half-cycle after a sampled key.
    initial forever begin
        @(posedge clk);
        if (newkey && keyCheck) begin
            @(negedge clk);
            if (keyQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL key_queue: got empty queue expected entry");
            end else begin
                keMon = keyQ.pop_front();
                checkOutput("key_disp", 32'(disp_value), 32'(keMon.disp));
                checkOutput("key_neg", 32'(neg_led), 32'(keMon.neg));
                checkOutput("key_ovw", 32'(ovw_led), 32'(keMon.ovw));
                checkOutput("key_busy", 32'(busy), 32'(keMon.busy));
            end
        end
    end

    // Global time limit.
    initial begin
        #(200 * 20000);
        $display("[TB] FAIL watchdog: got no finish expected finish within 20000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("rst_disp", 32'(disp_value), 32'h0);
        checkOutput("rst_ovw", 32'(ovw_led), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_start", 32'(alu_start), 32'h0);
        checkOutput("rst_a", 32'(alu_a), 32'h0);
        checkOutput("rst_b", 32'(alu_b), 32'h0);
        checkOutput("rst_op", 32'(alu_op), 32'h0);

        // Digit entry limit, backspace, clear entry.
        applyStimulus(5'h11, 16'h0001, 1'b0, 1'b0);
        applyStimulus(5'h12, 16'h0012, 1'b0, 1'b0);
        applyStimulus(5'h13, 16'h0123, 1'b0, 1'b0);
        applyStimulus(5'h14, 16'h1234, 1'b0, 1'b0);
        applyStimulus(5'h15, 16'h1234, 1'b0, 1'b0);
        applyStimulus(5'h06, 16'h0123, 1'b0, 1'b0);
        applyStimulus(5'h05, 16'h0000, 1'b0, 1'b0);

        // 7 + 5 with a 3-cycle ALU.
        applyStimulus(5'h00, 16'h0000, 1'b0, 1'b0);
        applyStimulus(5'h10, 16'h0000, 1'b0, 1'b0);
        applyStimulus(5'h10, 16'h0000, 1'b0, 1'b0);
        applyStimulus(5'h10, 16'h0000, 1'b0, 1'b0);
        applyStimulus(5'h17, 16'h0007, 1'b0, 1'b0);
        applyStimulus(5'h01, 16'h0007, 1'b0, 1'b0);
        applyStimulus(5'h10, 16'h0000, 1'b0, 1'b0);
        applyStimulus(5'h10, 16'h0000, 1'b0, 1'b0);
        applyStimulus(5'h10, 16'h0000, 1'b0, 1'b0);
        applyStimulus(5'h15, 16'h0005, 1'b0, 1'b0);
        pushIssue(16'h0007, 16'h0005, 2'b00);
        pushResp(3, 16'h000C, 1'b0);
        pushDone(16'h000C, 1'b0, 1'b0, 4);
        applyStimulus(5'h04, 16'h0005, 1'b0, 1'b1);
        waitIdle(20);

        // 3 - 5 = FFFE, negative display.
        applyStimulus(5'h13, 16'h0003, 1'b0, 1'b0);
        applyStimulus(5'h02, 16'h0003, 1'b0, 1'b0);
        applyStimulus(5'h15, 16'h0005, 1'b0, 1'b0);
        pushIssue(16'h0003, 16'h0005, 2'b01);
        pushResp(2, 16'hFFFE, 1'b0);
        pushDone(16'hFFFE, 1'b1, 1'b0, 3);
        applyStimulus(5'h04, 16'h0005, 1'b0, 1'b1);
        waitIdle(20);

        // Chain: 2 + 3 * 4.
        applyStimulus(5'h12, 16'h0002, 1'b0, 1'b0);
        applyStimulus(5'h01, 16'h0002, 1'b0, 1'b0);
        applyStimulus(5'h13, 16'h0003, 1'b0, 1'b0);
        pushIssue(16'h0002, 16'h0003, 2'b00);
        pushResp(1, 16'h0005, 1'b0);
        pushDone(16'h0005, 1'b0, 1'b0, 2);
        applyStimulus(5'h03, 16'h0003, 1'b0, 1'b1);
        waitIdle(20);
        applyStimulus(5'h14, 16'h0004, 1'b0, 1'b0);
        pushIssue(16'h0005, 16'h0004, 2'b10);
        pushResp(3, 16'h0014, 1'b0);
        pushDone(16'h0014, 1'b0, 1'b0, 4);
        applyStimulus(5'h04, 16'h0004, 1'b0, 1'b1);
        waitIdle(20);

        // Timeout: 3 * 6 with no done; a late done is ignored.
        applyStimulus(5'h13, 16'h0003, 1'b0, 1'b0);
        applyStimulus(5'h03, 16'h0003, 1'b0, 1'b0);
        applyStimulus(5'h16, 16'h0006, 1'b0, 1'b0);
        pushIssue(16'h0003, 16'h0006, 2'b10);
        pushDone(16'h0006, 1'b0, 1'b1, 64);
        applyStimulus(5'h04, 16'h0006, 1'b0, 1'b1);
        waitIdle(100);
        lateDone(16'hBEEF, 1'b0);
        applyStimulus(5'h07, 16'h0006, 1'b1, 1'b0);

        // Overflow flag from the ALU, then cleared by a clean result.
        applyStimulus(5'h00, 16'h0000, 1'b0, 1'b0);
        applyStimulus(5'h17, 16'h0007, 1'b0, 1'b0);
        applyStimulus(5'h01, 16'h0007, 1'b0, 1'b0);
        applyStimulus(5'h19, 16'h0009, 1'b0, 1'b0);
        pushIssue(16'h0007, 16'h0009, 2'b00);
        pushResp(1, 16'h0010, 1'b1);
        pushDone(16'h0010, 1'b0, 1'b1, 2);
        applyStimulus(5'h04, 16'h0009, 1'b0, 1'b1);
        waitIdle(20);
        applyStimulus(5'h01, 16'h0010, 1'b1, 1'b0);
        applyStimulus(5'h11, 16'h0001, 1'b1, 1'b0);
        pushIssue(16'h0010, 16'h0001, 2'b00);
        pushResp(2, 16'h0011, 1'b0);
        pushDone(16'h0011, 1'b0, 1'b0, 3);
        applyStimulus(5'h04, 16'h0001, 1'b1, 1'b1);
        waitIdle(20);

        // CLR during WAIT, then a late done must not latch.
        applyStimulus(5'h12, 16'h0002, 1'b0, 1'b0);
        applyStimulus(5'h03, 16'h0002, 1'b0, 1'b0);
        applyStimulus(5'h13, 16'h0003, 1'b0, 1'b0);
        pushIssue(16'h0002, 16'h0003, 2'b10);
        pushDone(16'h0000, 1'b0, 1'b0, -1);
        applyStimulus(5'h04, 16'h0003, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        applyStimulus(5'h00, 16'h0000, 1'b0, 1'b0);
        lateDone(16'h1234, 1'b1);
        applyStimulus(5'h07, 16'h0000, 1'b0, 1'b0);
        checkOutput("clr_a", 32'(alu_a), 32'h0);
        checkOutput("clr_b", 32'(alu_b), 32'h0);
        checkOutput("clr_op", 32'(alu_op), 32'h0);

        // Asynchronous reset in the middle of WAIT.
        applyStimulus(5'h15, 16'h0005, 1'b0, 1'b0);
        applyStimulus(5'h01, 16'h0005, 1'b0, 1'b0);
        applyStimulus(5'h16, 16'h0006, 1'b0, 1'b0);
        pushIssue(16'h0005, 16'h0006, 2'b00);
        pushDone(16'h0000, 1'b0, 1'b0, -1);
        applyStimulus(5'h04, 16'h0006, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #20 rstn = 1'b0;
        #1;
        checkOutput("arst_disp", 32'(disp_value), 32'h0);
        checkOutput("arst_busy", 32'(busy), 32'h0);
        checkOutput("arst_start", 32'(alu_start), 32'h0);
        checkOutput("arst_a", 32'(alu_a), 32'h0);
        checkOutput("arst_b", 32'(alu_b), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(5'h07, 16'h0000, 1'b0, 1'b0);
        applyStimulus(5'h1A, 16'h000A, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        checkOutput("queues_empty",
                    32'(issueQ.size() + doneQ.size() + keyQ.size() + respQ.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
